// File: rtl/hex_display_ctrl_if.sv
// rtl/hex_display_ctrl_if.sv - LSU IO bus port bundle for the seven-segment display controller
interface hex_display_ctrl_if #(
  parameter int ADDR_W = 5
);
  logic              st_en;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       st_data;
  logic              ld_en;
  logic [31:0]       ld_data;
  logic              ld_valid;

  modport master (
    output st_en, funct3, addr, st_data, ld_en,
    input  ld_data, ld_valid
  );

  modport slave (
    input  st_en, funct3, addr, st_data, ld_en,
    output ld_data, ld_valid
  );
endinterface

// File: rtl/hex_display_ctrl.sv
// rtl/hex_display_ctrl.sv - memory-mapped seven-segment controller with hex decode and blink
// Digit bytes sit at offsets 0..NUM_DIGITS-1, the control word at CTRL_OFF; segments are active-low.
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int ADDR_W     = 5,
  parameter int CTRL_OFF   = 16,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  hex_display_ctrl_if.slave       bus,
  output logic [7*NUM_DIGITS-1:0] o_io_hex
);
  localparam int CNT_W = $clog2(BLINK_DIV);

  logic [7:0]            digit_q [NUM_DIGITS];
  logic [7:0]            digit_d [NUM_DIGITS];
  logic [16:0]           ctrl_q, ctrl_d;
  logic [CNT_W-1:0]      blink_cnt_q;
  logic                  phase_q;
  logic [2:0]            n_lanes;
  logic [ADDR_W-1:0]     word_base;
  logic [31:0]           rd_word;
  logic [7*NUM_DIGITS-1:0] seg_d;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  // Each lane targets addr+k; lanes outside the digit or ctrl windows fall through untouched.
  always_comb begin
    digit_d = digit_q;
    ctrl_d  = ctrl_q;
    case (bus.funct3)
      3'd0:    n_lanes = 3'd1;
      3'd1:    n_lanes = 3'd2;
      3'd2:    n_lanes = 3'd4;
      default: n_lanes = 3'd0;
    endcase
    if (bus.st_en) begin
      for (int k = 0; k < 4; k++) begin
        if (k < int'(n_lanes)) begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (int'(bus.addr) + k == i) digit_d[i] = bus.st_data[8*k +: 8];
          end
          if (int'(bus.addr) + k == CTRL_OFF)     ctrl_d[7:0]  = bus.st_data[8*k +: 8];
          if (int'(bus.addr) + k == CTRL_OFF + 1) ctrl_d[15:8] = bus.st_data[8*k +: 8];
          if (int'(bus.addr) + k == CTRL_OFF + 2) ctrl_d[16]   = bus.st_data[8*k];
        end
      end
    end
  end

  assign word_base = {bus.addr[ADDR_W-1:2], 2'b00};

  always_comb begin
    rd_word = '0;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (int'(word_base) + b == i) rd_word[8*b +: 8] = digit_q[i];
      end
      if (int'(word_base) + b == CTRL_OFF)     rd_word[8*b +: 8] = ctrl_q[7:0];
      if (int'(word_base) + b == CTRL_OFF + 1) rd_word[8*b +: 8] = ctrl_q[15:8];
      if (int'(word_base) + b == CTRL_OFF + 2) rd_word[8*b +: 8] = {7'b0, ctrl_q[16]};
    end
  end

  always_comb begin
    seg_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (ctrl_q[16] && phase_q && ctrl_q[8+i])
        seg_d[7*i +: 7] = 7'h7F;
      else if (ctrl_q[i])
        seg_d[7*i +: 7] = glyph(digit_q[i][3:0]);
      else
        seg_d[7*i +: 7] = digit_q[i][6:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      digit_q      <= '{default: '0};
      ctrl_q       <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      bus.ld_data  <= '0;
      bus.ld_valid <= 1'b0;
      o_io_hex     <= '0;
    end else begin
      digit_q      <= digit_d;
      ctrl_q       <= ctrl_d;
      bus.ld_valid <= bus.ld_en;
      if (bus.ld_en) bus.ld_data <= rd_word;
      o_io_hex     <= seg_d;
      // Counting starts only once blink_en is already live; disabling clears on the write edge.
      if (!ctrl_q[16] || !ctrl_d[16]) begin
        blink_cnt_q <= '0;
        phase_q     <= 1'b0;
      end else if (blink_cnt_q == CNT_W'(BLINK_DIV - 1)) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + CNT_W'(1);
      end
    end
  end
endmodule
